control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Parametrised successor to the combinational opcode decoder: a registered fetch/decode/execute FSM.
//  Fetches instructions over a req/ack memory port, latches IR, advances PC and decodes the opcode.
//  Sequences multi-cycle execute states, resolves jumps and traps illegal opcodes.
//  Sits between instruction memory/data memory and the accumulator datapath.
// PARAMETERS
//  IR_W     16  instruction width; opcode = ir[IR_W-1 -: OP_W], operand = ir[AW-1:0]
//  OP_W     4   opcode field width (4..6)
//  AW       12  address/PC width; must satisfy AW <= IR_W-OP_W
//  RST_VEC  0   PC value loaded in RESET_PC
// PORTS
//  clk        in   1     single clock, all state changes on rising edge
//  reset      in   1     synchronous, active-high
//  mem_req    out  1     memory request; held until mem_ack
//  mem_we     out  1     write qualifier for mem_req (STORE only)
//  mem_addr   out  AW    pc in FETCH, operand in memory-execute states
//  mem_rdata  in   IR_W  read data, valid when mem_ack=1
//  mem_ack    in   1     completes request in the same cycle it is high (may be same cycle as req)
//  acc_neg    in   1     accumulator < 0
//  acc_zero   in   1     accumulator == 0
//  acc_we     out  1     one-cycle pulse: datapath writes ALU result to accumulator
//  out_we     out  1     one-cycle pulse: OUT instruction
//  state      out  8     current state encoding
//  ir         out  IR_W  instruction register
//  pc         out  AW    program counter
//  trap       out  1     sticky illegal-opcode flag
// BEHAVIOUR
//  Reset: state=RESET_PC(8'h00), pc=RST_VEC, ir=0, trap=0; all strobes 0. Reset wins over any event.
//  RESET_PC -> FETCH(8'h01) next cycle.
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc.
//    On mem_ack: ir<=mem_rdata, pc<=pc+1 (wraps mod 2^AW), go DECODE(8'h10); else stay.
//  DECODE: one cycle, no strobes. Opcode maps to exec state = {0,opcode}, except:
//    opcode 1 -> EXEC_JZERO(8'h11);
//    opcode 0, or opcode >= 16 -> TRAP(8'h12).
//    Valid: AND 02, ADD 03, STORE 04, JNEG 05, OR 06, LOAD 07, JUMP 08, XOR 09, OUT 0A, ADDI 0B,
//    SUB 0C, SHL 0D, SHR 0E, JPOS 0F, JZERO 11.
//  Memory-read execs (AND, ADD, OR, LOAD, XOR, SUB): mem_req=1, mem_addr=operand.
//    On mem_ack: acc_we=1 that cycle, go FETCH; else stay.
//  STORE: mem_req=1, mem_we=1, mem_addr=operand; on mem_ack go FETCH; acc_we=0.
//  ADDI, SHL, SHR: acc_we=1 for one cycle -> FETCH.  OUT: out_we=1 for one cycle -> FETCH.
//  JUMP: pc<=operand. JNEG: if acc_neg. JZERO: if acc_zero. JPOS: if !acc_neg && !acc_zero.
//    All jumps are one cycle -> FETCH. Flags are sampled in the exec cycle.
//  TRAP: trap<=1; stays in TRAP with all strobes 0 until reset.
//  Latency: non-memory instruction = 3 cycles at zero wait (FETCH, DECODE, EXEC);
//    memory instruction = 3 + wait cycles.
//  mem_req/mem_addr/mem_we are stable while waiting; no request is dropped or re-issued.
//  Reset asserted mid-wait aborts the request: mem_req=0 the cycle after reset.
//  Strobes are decoded from state (Moore) plus mem_ack (acc_we on memory reads), never registered late.
// STRUCTURE
//  Package ctl_pkg: the 8-bit state localparams above, opcode constants, and an is_mem_op function.
//  Sub-module opcode_map: combinational opcode -> next-state mapping, including illegal detection.
//  FSM, PC and IR live in control_sequencer.
// TESTING
//  Reset, then mem_ack=1 always, rdata=16'h7005 -> DECODE then state 07, mem_addr=005,
//    acc_we pulse, pc=1.
//  FETCH with ack delayed 3 cycles -> mem_req held 4 cycles, mem_addr=pc stable, ir updates only on ack.
//  JNEG 16'h5123:
//    acc_neg=1 -> pc=123;
//    acc_neg=0 -> pc unchanged (old+1).
//  JPOS, acc_zero=1 -> no jump.
//  Opcode 0 and opcode 1 (with acc_zero=1) -> TRAP/trap=1 sticky, then JZERO jumps.
//  pc=AW'hFFF fetch -> pc wraps to 0.
//  Reset during a STORE wait -> state 00 next cycle, mem_req=0.

Source files
------------

// File: rtl/ctl_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcode
// constants and state classification helpers.
package ctl_pkg;

  // State encoding is visible on the state port, so every value is fixed.
  // Execute states 02..0F equal their opcode, which keeps decode trivial.
  typedef enum logic [7:0] {
    ST_RESET_PC = 8'h00,
    ST_FETCH    = 8'h01,
    ST_AND      = 8'h02,
    ST_ADD      = 8'h03,
    ST_STORE    = 8'h04,
    ST_JNEG     = 8'h05,
    ST_OR       = 8'h06,
    ST_LOAD     = 8'h07,
    ST_JUMP     = 8'h08,
    ST_XOR      = 8'h09,
    ST_OUT      = 8'h0A,
    ST_ADDI     = 8'h0B,
    ST_SUB      = 8'h0C,
    ST_SHL      = 8'h0D,
    ST_SHR      = 8'h0E,
    ST_JPOS     = 8'h0F,
    ST_DECODE   = 8'h10,
    ST_JZERO    = 8'h11,
    ST_TRAP     = 8'h12
  } state_e;

  // Opcodes that do not map straight onto their own execute state.
  localparam int OP_ILLEGAL   = 0;   // reserved, always traps
  localparam int OP_JZERO     = 1;   // would collide with FETCH, relocated to 8'h11
  localparam int OP_LEGAL_LIM = 16;  // wider opcode fields above this are unused

  // Execute states that own the memory port (reads and STORE).
  function automatic logic is_mem_op(state_e s);
    return s inside {ST_AND, ST_ADD, ST_OR, ST_LOAD, ST_XOR, ST_SUB, ST_STORE};
  endfunction

  // Execute states whose memory read data is loaded into the accumulator.
  function automatic logic is_mem_rd(state_e s);
    return s inside {ST_AND, ST_ADD, ST_OR, ST_LOAD, ST_XOR, ST_SUB};
  endfunction

endpackage

// File: rtl/opcode_map.sv
// Combinational opcode to execute-state mapping with illegal-opcode detection.
module opcode_map
  import ctl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode_i,
  output state_e          exec_state_o,
  output logic            illegal_o
);

  logic [7:0] op8;

  // Zero-extend the opcode and pick the execute state it selects.
  always_comb begin
    op8          = 8'(opcode_i);
    illegal_o    = 1'b0;
    exec_state_o = ST_TRAP;
    if (op8 == 8'(OP_ILLEGAL) || op8 >= 8'(OP_LEGAL_LIM)) begin
      illegal_o    = 1'b1;
      exec_state_o = ST_TRAP;
    end else if (op8 == 8'(OP_JZERO)) begin
      exec_state_o = ST_JZERO;
    end else begin
      exec_state_o = state_e'(op8);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: owns PC, IR and the trap flag, drives the
// memory request port and the accumulator/output write strobes.
module control_sequencer
  import ctl_pkg::*;
#(
  parameter int            IR_W    = 16,
  parameter int            OP_W    = 4,
  parameter int            AW      = 12,
  parameter logic [AW-1:0] RST_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  input  logic [IR_W-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            acc_neg,
  input  logic            acc_zero,
  output logic            acc_we,
  output logic            out_we,
  output logic [7:0]      state,
  output logic [IR_W-1:0] ir,
  output logic [AW-1:0]   pc,
  output logic            trap
);

  state_e          state_q;
  logic [IR_W-1:0] ir_q;
  logic [AW-1:0]   pc_q;
  logic            trap_q;

  logic [OP_W-1:0] opcode;
  logic [AW-1:0]   operand;
  state_e          dec_state;
  logic            dec_illegal;

  assign opcode  = ir_q[IR_W-1 -: OP_W];
  assign operand = ir_q[AW-1:0];

  opcode_map #(
    .OP_W (OP_W)
  ) u_opcode_map (
    .opcode_i     (opcode),
    .exec_state_o (dec_state),
    .illegal_o    (dec_illegal)
  );

  // Sequencer state, program counter, instruction register and sticky trap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET_PC;
      pc_q    <= RST_VEC;
      ir_q    <= '0;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET_PC: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ack) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + AW'(1);
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: state_q <= dec_illegal ? ST_TRAP : dec_state;
        ST_AND, ST_ADD, ST_OR, ST_LOAD, ST_XOR, ST_SUB, ST_STORE: begin
          // Hold the request unchanged until the memory acknowledges it.
          if (mem_ack) state_q <= ST_FETCH;
        end
        ST_JUMP: begin
          pc_q    <= operand;
          state_q <= ST_FETCH;
        end
        ST_JNEG: begin
          if (acc_neg) pc_q <= operand;
          state_q <= ST_FETCH;
        end
        ST_JZERO: begin
          if (acc_zero) pc_q <= operand;
          state_q <= ST_FETCH;
        end
        ST_JPOS: begin
          if (!acc_neg && !acc_zero) pc_q <= operand;
          state_q <= ST_FETCH;
        end
        ST_ADDI, ST_SHL, ST_SHR, ST_OUT: state_q <= ST_FETCH;
        ST_TRAP: trap_q <= 1'b1;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  // Moore strobes from the current state; read-type execs also qualify on ack.
  always_comb begin
    mem_req  = (state_q == ST_FETCH) || is_mem_op(state_q);
    mem_we   = (state_q == ST_STORE);
    mem_addr = (state_q == ST_FETCH) ? pc_q : operand;
    acc_we   = (is_mem_rd(state_q) && mem_ack) ||
               (state_q inside {ST_ADDI, ST_SHL, ST_SHR});
    out_we   = (state_q == ST_OUT);
  end

  assign state = state_q;
  assign ir    = ir_q;
  assign pc    = pc_q;
  assign trap  = trap_q;

endmodule
